// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the requester-side and downstream-side stream signals of the
// round-robin arbiter. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the requesters and sinks the output.
interface stream_rr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
  logic [NUM_REQ-1:0]            s_valid;
  logic [NUM_REQ-1:0]            s_last;
  logic [NUM_REQ-1:0]            s_ready;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          m_valid;
  logic                          m_last;
  logic [ID_WIDTH-1:0]           m_id;
  logic                          m_ready;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last, m_id
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last, m_id
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter with packet lock: shares one downstream valid/ready
// stream between NUM_REQ requesters. A grant is taken in IDLE (one bubble
// cycle) and held in BUSY until the granted requester's last beat transfers.
// Each output beat carries the index of its source requester on m_id.
module stream_rr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 64,
  localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_rr_arbiter_if.slave  bus
);

  localparam int CNT_W = ID_WIDTH + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

  logic                  pick_found_s;
  logic [ID_WIDTH-1:0]   pick_id_s;
  logic                  sel_valid_s;
  logic                  sel_last_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [NUM_REQ-1:0]    sel_ready_s;
  logic [NUM_REQ-1:0]    s_ready_s;
  logic [DATA_WIDTH-1:0] m_data_s;
  logic                  m_valid_s;
  logic                  m_last_s;
  logic [ID_WIDTH-1:0]   m_id_s;
  logic                  xfer_s;

  // (base + off) mod NUM_REQ; explicit wrap keeps non-power-of-2 counts correct.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                    input int off);
    logic [CNT_W-1:0] sum;
    sum = {1'b0, base} + CNT_W'(off);
    if (sum >= CNT_W'(NUM_REQ)) begin
      sum = sum - CNT_W'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[ID_WIDTH-1:0];
  endfunction

  // State register: FSM state, locked grant and round-robin priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Round-robin search: first valid requester scanning from ptr upward with wrap.
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found_s && bus.s_valid[wrap_add(ptr_q, k)]) begin
        pick_found_s = 1'b1;
        pick_id_s    = wrap_add(ptr_q, k);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Lane select: route the granted requester's signals and its ready bit.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = '0;
    sel_ready_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == gnt_q) begin
        sel_valid_s    = bus.s_valid[i];
        sel_last_s     = bus.s_last[i];
        sel_data_s     = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ready_s[i] = bus.m_ready;
      end else begin
        sel_ready_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic: grant in IDLE, release and advance ptr on the last beat.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          state_d = BUSY;
          gnt_d   = pick_id_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (xfer_s && m_last_s) begin
          state_d = IDLE;
          ptr_d   = wrap_add(gnt_q, 1);
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: everything forced to zero outside BUSY.
  always_comb begin
    s_ready_s = '0;
    m_data_s  = '0;
    m_valid_s = 1'b0;
    m_last_s  = 1'b0;
    m_id_s    = '0;
    case (state_q)
      IDLE: begin
        m_valid_s = 1'b0;
      end
      BUSY: begin
        s_ready_s = sel_ready_s;
        m_data_s  = sel_data_s;
        m_valid_s = sel_valid_s;
        m_last_s  = sel_last_s;
        m_id_s    = gnt_q;
      end
      default: begin
        m_valid_s = 1'b0;
      end
    endcase
  end

  assign xfer_s      = m_valid_s & bus.m_ready;

  assign bus.s_ready = s_ready_s;
  assign bus.m_data  = m_data_s;
  assign bus.m_valid = m_valid_s;
  assign bus.m_last  = m_last_s;
  assign bus.m_id    = m_id_s;

endmodule
